serial_rx_reg: RTL and testbench
================================

# serial_rx_reg

Serial-to-parallel receiver: the far end of the 8-bit universal shift register's `serial_out` stream. Captures a framed bit stream one bit per clock, MSB-first or LSB-first, and presents the reassembled word on a registered parallel output with a valid/ready handshake. Sits between the serial link and any parallel consumer, such as a register file or display logic.

## Interface
- `WIDTH`, default 8: data bits per frame.
- `clk` in, 1: single clock; all logic on the rising edge.
- `reset` in, 1: synchronous, active-low reset.
- `serial_in` in, 1: serial data bit, sampled every rising edge.
- `frame_start` in, 1: marks the cycle carrying the first bit of a frame.
- `msb_first` in, 1: bit order.
  - 1 = MSB first, matching a transmitter shifting left.
  - 0 = LSB first, matching a transmitter shifting right.
  - Sampled only with `frame_start`.
- `out_ready` in, 1: consumer accepts `qdata`.
- `qdata` out, WIDTH: last completed word.
- `q_valid` out, 1: `qdata` holds an unconsumed word.
- `busy` out, 1: a frame is in progress.
- `overrun` out, 1: sticky; a completed word was dropped.
- `parity_err` out, 1: parity mismatch on the current `qdata`. Tied 0 without `SERIAL_RX_PARITY_EN`.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE -> SHIFT when `frame_start`=1.
  - That cycle's `serial_in` is bit 0 of the frame.
  - `msb_first` is latched for the whole frame.
  - The bit counter loads 1.
- In SHIFT, one bit is shifted in per cycle.
  - `msb_first`=1: shift left, new bit into the LSB.
  - `msb_first`=0: shift right, new bit into the MSB.
- Frame length N = WIDTH, or WIDTH+1 with parity.
  - On the edge that samples bit N-1, the FSM returns to IDLE and the word is delivered.
- `frame_start` seen while in SHIFT is a resync.
  - The partial frame is discarded silently.
  - The counter restarts at 1 with the current bit.
  - The direction is re-latched.
- Delivery when `q_valid`=0, or `q_valid`=1 with `out_ready`=1 on the same edge: `qdata` <= the new word and `q_valid`=1.
- Delivery when `q_valid`=1 and `out_ready`=0: the new word is dropped, `qdata` is unchanged, and `overrun` <= 1.
- Consume: `q_valid`=1 and `out_ready`=1 on an edge with no delivery clears `q_valid`. `qdata` keeps its value.
- `overrun` clears only on reset.
- `busy` = (state == SHIFT).
- Reset (`reset`=0 at an edge):
  - State goes to IDLE and the counter to 0.
  - `qdata`=0, `q_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0.
  - Takes priority over every other input, including mid-frame. Any partial frame is lost.

## Timing
- With `frame_start` in cycle 0, the data bits occupy cycles 0..WIDTH-1.
  - `q_valid` rises in cycle N: one cycle after the last bit is sampled.
- Back-to-back frames: `frame_start` is accepted in cycle N, the first cycle after the last bit. There are no dead cycles.
- Throughput: one word per N cycles.
- `qdata` and `q_valid` are register outputs with no combinational path from inputs. `busy` changes on the edges that enter and leave SHIFT.
- `q_valid` stays high until it is consumed. `qdata` is stable for as long as `q_valid`=1.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - Frames are WIDTH data bits plus one trailing even-parity bit.
  - `parity_err` = XOR of the data bits and the parity bit. It is registered with `qdata` and updates only when `qdata` updates.
  - A word with bad parity is still delivered.
- Not defined:
  - Frames are WIDTH bits.
  - `parity_err` is a constant 0.

## Structure
- Package `serial_pkg`:
  - state enum (IDLE, SHIFT);
  - `SERIAL_DEFAULT_WIDTH` = 8;
  - `BIT_ORDER_MSB` = 1 and `BIT_ORDER_LSB` = 0.
- Sub-module `serial_rx_shifter`: a WIDTH-bit shift register with enable, clear and direction input.
- The top level holds the FSM, the counter sized by `$clog2(WIDTH+2)`, the output register and the handshake logic.

## Test plan
- MSB-first: `frame_start` with bits 0,0,0,1,0,1,1,1, `out_ready`=1 -> `qdata`=8'b0001_0111 and `q_valid`=1 for one cycle, in cycle 8.
- LSB-first: bits 1,1,1,0,1,0,0,0 -> `qdata`=8'b0001_0111. Repeat back-to-back with `frame_start` in cycle 8 -> two words, no gap, `overrun`=0.
- Overrun: `out_ready`=0, frames 8'hA5 then 8'h3C -> `qdata`=8'hA5 and `overrun`=1. Raise `out_ready` -> `q_valid` drops the next cycle; `overrun` stays 1.
- Resync: `frame_start` again at bit 3 of a frame, then 8 bits of 8'hC3 -> `qdata`=8'hC3 with exactly one delivery.
- Reset mid-frame: `reset`=0 at bit 4 -> all outputs 0 and `busy`=0. A following full frame of 8'h81 is received correctly.
- `SERIAL_RX_PARITY_EN`: frame 8'h17 with parity bit 0 -> `parity_err`=0. The same data with parity bit 1 -> `parity_err`=1 and `qdata`=8'h17.

Source files
------------

// File: rtl/serial_rx_reg_pkg.sv
// Shared types and constants for the serial receiver.
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;

  localparam int   SERIAL_DEFAULT_WIDTH = 8;
  localparam logic BIT_ORDER_MSB        = 1'b1;
  localparam logic BIT_ORDER_LSB        = 1'b0;
endpackage

// File: rtl/serial_rx_shifter.sv
// WIDTH-bit deserialising shift register. data_d exposes the post-edge value so
// the top can capture the word on the same edge that samples its last bit.
module serial_rx_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  input  logic             din,
  output logic [WIDTH-1:0] data_q,
  output logic [WIDTH-1:0] data_d
);
  logic [WIDTH-1:0] base;

  // clr drops the previous contents so a new frame starts from a clean word.
  always_comb begin
    base   = clr ? '0 : data_q;
    data_d = data_q;
    if (en) begin
      if (dir == BIT_ORDER_MSB) data_d = {base[WIDTH-2:0], din};
      else                      data_d = {din, base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end
endmodule

// File: rtl/serial_rx_reg.sv
// Serial-to-parallel receiver with valid/ready output register.
// Optional trailing even-parity bit: define SERIAL_RX_PARITY_EN.
module serial_rx_reg
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             frame_start,
  input  logic             msb_first,
  input  logic             out_ready,
  output logic [WIDTH-1:0] qdata,
  output logic             q_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);
`ifdef SERIAL_RX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [CW-1:0] DATA_BITS = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] qdata_q, qdata_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;
  logic             shift_en, shift_dir, frame_done;
  logic [WIDTH-1:0] shift_q, shift_d;

  serial_rx_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .en     (shift_en),
    .clr    (frame_start),
    .dir    (shift_dir),
    .din    (serial_in),
    .data_q (shift_q),
    .data_d (shift_d)
  );

  // A frame_start always wins, which also covers resync in SHIFT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    shift_dir  = frame_start ? msb_first : dir_q;
    if (frame_start) begin
      state_d    = SHIFT;
      cnt_d      = CW'(1);
      dir_d      = msb_first;
      shift_en   = 1'b1;
      frame_done = (N == 1);
    end else if (state_q == SHIFT) begin
      shift_en = (cnt_q < DATA_BITS);
      if (cnt_q == LAST_IDX) frame_done = 1'b1;
      else                   cnt_d = cnt_q + CW'(1);
    end
    if (frame_done) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  logic deliver;

  always_comb begin
    qdata_d   = qdata_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;
    deliver   = 1'b0;
    if (frame_done) begin
      if (!q_valid_q || out_ready) begin
        qdata_d   = shift_d;
        q_valid_d = 1'b1;
        deliver   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (q_valid_q && out_ready) begin
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= BIT_ORDER_LSB;
      qdata_q   <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      qdata_q   <= qdata_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic perr_q, perr_d;

  // On the parity cycle the shifter holds, so shift_d is the data word.
  always_comb begin
    perr_d = perr_q;
    if (deliver) perr_d = (^shift_d) ^ serial_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign qdata   = qdata_q;
  assign q_valid = q_valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q == SHIFT);
endmodule

// File: tb/tb_serial_rx_reg.sv
// Directed bench for serial_rx_reg; parity cases enabled by SERIAL_RX_PARITY_EN.
module tb_serial_rx_reg;
  localparam int W = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         serial_in;
  logic         frame_start;
  logic         msb_first;
  logic         out_ready;
  logic [W-1:0] qdata;
  logic         q_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int errors = 0;
  int checks = 0;

  serial_rx_reg #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .frame_start (frame_start),
    .msb_first   (msb_first),
    .out_ready   (out_ready),
    .qdata       (qdata),
    .q_valid     (q_valid),
    .busy        (busy),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives frame bit positions first..last; position >= W is the parity bit.
  task automatic send(input logic [W-1:0] data, input logic msb,
                      input int first, input int last, input logic pflip);
    for (int i = first; i <= last; i++) begin
      frame_start = (i == 0);
      if (i == 0) msb_first = msb;
      if (i >= W)   serial_in = (^data) ^ pflip;
      else if (msb) serial_in = data[W-1-i];
      else          serial_in = data[i];
      tick();
    end
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; serial_in = 1'b0; frame_start = 1'b0;
    msb_first = 1'b0; out_ready = 1'b1;
    tick();
    chk("rst_qdata",   qdata, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_perr",    parity_err, 0);
    reset = 1'b1;
    tick();

    // MSB-first 0x17
    send(8'h17, 1'b1, 0, 0, 1'b0);
    chk("msb_busy_first", busy, 1);
    send(8'h17, 1'b1, 1, N-1, 1'b0);
    chk("msb_qdata",   qdata, 8'h17);
    chk("msb_q_valid", q_valid, 1);
    chk("msb_busy_end", busy, 0);
    chk("msb_perr",    parity_err, 0);
    tick();
    chk("msb_consumed", q_valid, 0);
    chk("msb_hold",     qdata, 8'h17);

    // LSB-first back-to-back
    send(8'h17, 1'b0, 0, N-1, 1'b0);
    chk("lsb_qdata1",   qdata, 8'h17);
    chk("lsb_q_valid1", q_valid, 1);
    send(8'h6B, 1'b0, 0, N-1, 1'b0);
    chk("lsb_qdata2",   qdata, 8'h6B);
    chk("lsb_q_valid2", q_valid, 1);
    chk("lsb_overrun",  overrun, 0);
    tick();
    chk("lsb_consumed", q_valid, 0);

    // Overrun
    out_ready = 1'b0;
    send(8'hA5, 1'b1, 0, N-1, 1'b0);
    chk("ovr_qdata1",  qdata, 8'hA5);
    chk("ovr_flag1",   overrun, 0);
    send(8'h3C, 1'b1, 0, N-1, 1'b0);
    chk("ovr_qdata2",  qdata, 8'hA5);
    chk("ovr_q_valid", q_valid, 1);
    chk("ovr_flag2",   overrun, 1);
    out_ready = 1'b1;
    tick();
    chk("ovr_consumed", q_valid, 0);
    chk("ovr_sticky",   overrun, 1);
    chk("ovr_hold",     qdata, 8'hA5);

    // Resync at bit 3; out_ready low so any stray delivery would stick
    out_ready = 1'b0;
    send(8'hFF, 1'b1, 0, 2, 1'b0);
    send(8'hC3, 1'b1, 0, N-2, 1'b0);
    chk("rsy_no_stray", q_valid, 0);
    chk("rsy_busy",     busy, 1);
    send(8'hC3, 1'b1, N-1, N-1, 1'b0);
    chk("rsy_qdata",   qdata, 8'hC3);
    chk("rsy_q_valid", q_valid, 1);

    // Reset mid-frame with a word pending and overrun set
    send(8'hFF, 1'b1, 0, 3, 1'b0);
    chk("mid_busy", busy, 1);
    serial_in = 1'b1;
    reset = 1'b0;
    tick();
    chk("mrst_qdata",   qdata, 0);
    chk("mrst_q_valid", q_valid, 0);
    chk("mrst_busy",    busy, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_perr",    parity_err, 0);
    reset = 1'b1;
    out_ready = 1'b1;
    send(8'h81, 1'b0, 0, N-1, 1'b0);
    chk("post_qdata",   qdata, 8'h81);
    chk("post_q_valid", q_valid, 1);
    chk("post_overrun", overrun, 0);
    tick();

`ifdef SERIAL_RX_PARITY_EN
    send(8'h17, 1'b1, 0, N-1, 1'b0);
    chk("par_good_perr",  parity_err, 0);
    chk("par_good_qdata", qdata, 8'h17);
    send(8'h17, 1'b1, 0, N-1, 1'b1);
    chk("par_bad_perr",   parity_err, 1);
    chk("par_bad_qdata",  qdata, 8'h17);
    chk("par_bad_valid",  q_valid, 1);
`else
    send(8'hE8, 1'b0, 0, N-1, 1'b0);
    chk("nopar_qdata", qdata, 8'hE8);
    chk("nopar_perr",  parity_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
